// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types and constants for the ring round-robin arbiter.
// Build option: ARB_TIMEOUT_EN enables owner preemption after MAX_HOLD cycles.
package ring_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Reset value of the one-hot priority pointer: requester 0 first.
    localparam int PTR_RESET = 1;

    // Index width for an N-requester arbiter (IDW = clog2(N)).
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ring_rr_arbiter_rr_pick.sv
// Combinational rotating-priority select: first set bit of req & ~excl,
// scanning upward from the one-hot ptr position with wrap.
module rr_pick
    import ring_rr_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   ptr,
    input  logic [N-1:0]   excl,
    output logic [N-1:0]   win,
    output logic [IDW-1:0] win_id
);

    always_comb begin : p_pick
        logic [N-1:0] cand;
        logic         found;
        int           idx;
        // NOTE: every variable gets a default before the loops so no path leaves it unassigned (no latch).
        cand   = req & ~excl;
        found  = 1'b0;
        idx    = 0;
        win    = '0;
        win_id = '0;
        for (int s = 0; s < N; s++) begin
            if (ptr[s]) begin
                for (int k = 0; k < N; k++) begin
                    idx = (s + k) % N;
                    if (!found && cand[idx]) begin
                        found    = 1'b1;
                        win[idx] = 1'b1;
                        win_id   = IDW'(idx);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and registered grant.
// Build option: define ARB_TIMEOUT_EN to preempt owners after MAX_HOLD cycles.
module ring_rr_arbiter
    import ring_rr_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    output logic [N-1:0]           gnt,
    output logic [id_width(N)-1:0] gnt_id,
    output logic                   busy,
    output logic                   timeout
);

    localparam int IDW = id_width(N);

    if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_bad_params
        $error("ring_rr_arbiter: N must be 2..16 and MAX_HOLD >= 1");
    end

    arb_state_t     state, state_d;
    logic [N-1:0]   ptr, ptr_d, gnt_d;
    logic [IDW-1:0] gnt_id_d;
    logic [N-1:0]   past_owner, pick_ptr, pick_excl, pick_win;
    logic [IDW-1:0] pick_id;
    logic           handoff, expire;

    assign past_owner = {gnt[N-2:0], gnt[N-1]};

    // While owning, the next winner is scanned from just past the owner and never re-selects it.
    assign pick_ptr  = (state == OWN) ? past_owner : ptr;
    assign pick_excl = (state == OWN) ? gnt : '0;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .excl   (pick_excl),
        .win    (pick_win),
        .win_id (pick_id)
    );

    assign handoff = (state == OWN) && (!req[gnt_id] || expire);

`ifdef ARB_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD) + 1;
    logic [HCW-1:0] hold_cnt, hold_d;
    logic           timeout_q;

    assign expire = (state == OWN) && req[gnt_id] && (hold_cnt == HCW'(MAX_HOLD - 1));

    always_comb begin
        hold_d = '0;
        if (state == OWN && !handoff) hold_d = hold_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_d;
            timeout_q <= expire;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        gnt_d    = gnt;
        gnt_id_d = gnt_id;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    gnt_d    = pick_win;
                    gnt_id_d = pick_id;
                    state_d  = OWN;
                end
            end
            OWN: begin
                if (handoff) begin
                    ptr_d    = past_owner;
                    gnt_d    = pick_win;
                    gnt_id_d = pick_id;
                    state_d  = (|pick_win) ? OWN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= N'(PTR_RESET);
            gnt    <= '0;
            gnt_id <= '0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            gnt    <= gnt_d;
            gnt_id <= gnt_id_d;
        end
    end

    assign busy = |gnt;

endmodule
